// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller: stage indices,
// operating modes and the per-mode control-word helper.
package pipe_hazard_ctrl_pkg;

  localparam int NUM_REGS_DEF = 16;
  localparam int REG_AW_DEF   = 4;
  localparam int MUL_LAT_DEF  = 4;
  localparam int CNT_W_DEF    = 32;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STALL,
    MODE_FLUSH,
    MODE_BUSY
  } mode_e;

  typedef struct packed {
    logic [4:0] en;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       ex_mem_bubble;
  } ctl_t;

  function automatic ctl_t mode_ctl(input mode_e m);
    ctl_t c;
    c.en            = '1;
    c.if_id_flush   = 1'b0;
    c.id_ex_bubble  = 1'b0;
    c.ex_mem_bubble = 1'b0;
    case (m)
      MODE_BUSY: begin
        // Front end frozen behind the multi-cycle op; back end drains.
        c.en[STG_IF]    = 1'b0;
        c.en[STG_ID]    = 1'b0;
        c.en[STG_EX]    = 1'b0;
        c.ex_mem_bubble = 1'b1;
      end
      MODE_FLUSH: begin
        c.if_id_flush  = 1'b1;
        c.id_ex_bubble = 1'b1;
      end
      MODE_STALL: begin
        c.en[STG_IF]   = 1'b0;
        c.en[STG_ID]   = 1'b0;
        c.id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on WB
// (set wins on collision); pend_eff exposes WB write-through in the same cycle.
module pipe_hazard_ctrl_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_set_vld,
  input  logic [REG_AW-1:0]   i_set_idx,
  input  logic                i_clr_vld,
  input  logic [REG_AW-1:0]   i_clr_idx,
  output logic [NUM_REGS-1:0] o_pend_eff
);

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  // r0 is hardwired, so it is never allowed to become pending.
  assign w_set_mask = (i_set_vld && i_set_idx != '0) ? (NUM_REGS'(1) << i_set_idx) : '0;
  assign w_clr_mask = i_clr_vld ? (NUM_REGS'(1) << i_clr_idx) : '0;
  assign o_pend_eff = r_pend & ~w_clr_mask;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline enable/flush/bubble generator; outputs are combinational (0-cycle),
// busy > branch flush > RAW/WAW stall > run. Optional counters: PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MUL_LAT  = MUL_LAT_DEF
`ifdef PIPE_HAZARD_PERF_EN
  ,
  parameter int CNT_W    = CNT_W_DEF
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_wr,
  input  logic              i_id_multi,
  input  logic              i_ex_branch_taken,
  input  logic              i_wb_wr,
  input  logic [REG_AW-1:0] i_wb_rd,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [CNT_W-1:0]  o_stall_cycles,
  output logic [CNT_W-1:0]  o_flush_count,
`endif
  output logic              o_if_en,
  output logic              o_id_en,
  output logic              o_ex_en,
  output logic              o_mem_en,
  output logic              o_wb_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic              o_ex_mem_bubble
);

  localparam int BW = $clog2(MUL_LAT);

  logic [BW-1:0]       r_busy_cnt;
  logic [NUM_REGS-1:0] w_pend_eff;
  logic                w_busy;
  logic                w_hazard;
  logic                w_issue;
  mode_e               w_mode;
  ctl_t                w_ctl;

  assign w_busy   = (r_busy_cnt != '0);
  assign w_hazard = i_id_valid &
                    ((i_id_rs1_used & w_pend_eff[i_id_rs1]) |
                     (i_id_rs2_used & w_pend_eff[i_id_rs2]) |
                     (i_id_wr       & w_pend_eff[i_id_rd]));
  assign w_issue  = i_rst_n & i_id_valid & (w_mode == MODE_RUN);

  always_comb begin
    w_mode = MODE_RUN;
    if (w_busy)                 w_mode = MODE_BUSY;
    else if (i_ex_branch_taken) w_mode = MODE_FLUSH;
    else if (w_hazard)          w_mode = MODE_STALL;
    w_ctl = mode_ctl(w_mode);
    if (!i_rst_n) begin
      w_ctl.en            = '0;
      w_ctl.if_id_flush   = 1'b1;
      w_ctl.id_ex_bubble  = 1'b1;
      w_ctl.ex_mem_bubble = 1'b1;
    end
  end

  assign o_if_en         = w_ctl.en[STG_IF];
  assign o_id_en         = w_ctl.en[STG_ID];
  assign o_ex_en         = w_ctl.en[STG_EX];
  assign o_mem_en        = w_ctl.en[STG_MEM];
  assign o_wb_en         = w_ctl.en[STG_WB];
  assign o_if_id_flush   = w_ctl.if_id_flush;
  assign o_id_ex_bubble  = w_ctl.id_ex_bubble;
  assign o_ex_mem_bubble = w_ctl.ex_mem_bubble;

  pipe_hazard_ctrl_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set_vld  (w_issue & i_id_wr),
    .i_set_idx  (i_id_rd),
    .i_clr_vld  (i_wb_wr),
    .i_clr_idx  (i_wb_rd),
    .o_pend_eff (w_pend_eff)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy_cnt <= '0;
    end else if (w_busy) begin
      r_busy_cnt <= r_busy_cnt - BW'(1);
    end else if (w_issue && i_id_multi) begin
      r_busy_cnt <= BW'(MUL_LAT - 1);
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_ctl.en[STG_IF] && r_stall_cycles != '1)
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_mode == MODE_FLUSH && r_flush_count != '1)
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;
`endif

endmodule
